// File: rtl/bp_local_hist.sv
// bp_local_hist: two-level local-history branch predictor with table init sweep and perf counters.
// Optional feature: define BP_BYPASS_EN to forward a same-cycle M update into the F lookup.
module bp_local_hist #(
  parameter int BHT_IDX_W = 3,
  parameter int HIST_W    = 4,
  parameter int PC2_W     = 3,
  parameter int CTR_W     = 2,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] pc_idx_F,
  input  logic [PC2_W-1:0]     pc2_idx_F,
  output logic                 pred_taken_F,
  output logic [HIST_W-1:0]    pred_hist_F,
  input  logic                 update_valid_M,
  input  logic [BHT_IDX_W-1:0] pc_idx_M,
  input  logic [PC2_W-1:0]     pc2_idx_M,
  input  logic [HIST_W-1:0]    hist_M,
  input  logic                 taken_M,
  input  logic                 mispredict_M,
  input  logic                 clr_cnt,
  output logic                 init_busy,
  output logic [CNT_W-1:0]     br_cnt,
  output logic [CNT_W-1:0]     mis_cnt
);

  localparam int PHT_IDX_W = PC2_W + HIST_W;
  localparam int PHT_N     = 32'd1 << PHT_IDX_W;
  localparam int BHT_N     = 32'd1 << BHT_IDX_W;
  // Sweep covers the larger of the two tables; N is always a power of two.
  localparam int SW_W      = (PHT_IDX_W > BHT_IDX_W) ? PHT_IDX_W : BHT_IDX_W;

  localparam logic [SW_W-1:0]  SW_LAST  = {SW_W{1'b1}};
  localparam logic [SW_W-1:0]  SW_ONE   = {{(SW_W-1){1'b0}}, 1'b1};
  localparam logic [SW_W:0]    PHT_LIM  = (SW_W+1)'(PHT_N);
  localparam logic [SW_W:0]    BHT_LIM  = (SW_W+1)'(BHT_N);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                state_r;
  logic [SW_W-1:0]       sweep_idx_r;
  logic [CTR_W-1:0]      pht_r [PHT_N];
  logic [HIST_W-1:0]     bht_r [BHT_N];

  logic                  upd_s;
  logic [PHT_IDX_W-1:0]  pht_idx_m_s;
  logic [CTR_W-1:0]      ctr_old_m_s;
  logic [CTR_W-1:0]      ctr_new_m_s;
  logic [HIST_W-1:0]     new_hist_s;
  logic [HIST_W-1:0]     hist_f_s;
  logic [PHT_IDX_W-1:0]  pidx_f_s;
  logic [CTR_W-1:0]      ctr_f_s;
  logic                  sweep_in_pht_s;
  logic                  sweep_in_bht_s;

  assign init_busy      = (state_r == INIT);
  assign upd_s          = update_valid_M & (state_r == RUN);
  assign pht_idx_m_s    = {pc2_idx_M, hist_M};
  assign ctr_old_m_s    = pht_r[pht_idx_m_s];
  assign sweep_in_pht_s = ({1'b0, sweep_idx_r} < PHT_LIM);
  assign sweep_in_bht_s = ({1'b0, sweep_idx_r} < BHT_LIM);

  // Training uses the carried checkpoint hist_M, never the live BHT entry.
  generate
    if (HIST_W == 1) begin : g_hist1
      assign new_hist_s = taken_M;
    end else begin : g_histn
      assign new_hist_s = {hist_M[HIST_W-2:0], taken_M};
    end
  endgenerate

  // Saturating next value of the M-stage pattern counter.
  always_comb begin
    ctr_new_m_s = ctr_old_m_s;
    if (taken_M) begin
      if (ctr_old_m_s != CTR_MAX) ctr_new_m_s = ctr_old_m_s + CTR_ONE;
      else                        ctr_new_m_s = ctr_old_m_s;
    end else begin
      if (ctr_old_m_s != CTR_ZERO) ctr_new_m_s = ctr_old_m_s - CTR_ONE;
      else                         ctr_new_m_s = ctr_old_m_s;
    end
  end

  // Fetch-stage lookup, with optional forwarding of the in-flight update.
  always_comb begin
    hist_f_s = bht_r[pc_idx_F];
`ifdef BP_BYPASS_EN
    if (upd_s && (pc_idx_F == pc_idx_M)) hist_f_s = new_hist_s;
    else                                 hist_f_s = bht_r[pc_idx_F];
    pidx_f_s = {pc2_idx_F, hist_f_s};
    if (upd_s && (pidx_f_s == pht_idx_m_s)) ctr_f_s = ctr_new_m_s;
    else                                    ctr_f_s = pht_r[pidx_f_s];
`else
    pidx_f_s = {pc2_idx_F, hist_f_s};
    ctr_f_s  = pht_r[pidx_f_s];
`endif
  end

  assign pred_taken_F = ctr_f_s[CTR_W-1] & ~init_busy;
  assign pred_hist_F  = hist_f_s;

  // Init/run FSM and sweep index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= INIT;
      sweep_idx_r <= {SW_W{1'b0}};
    end else begin
      case (state_r)
        INIT: begin
          if (sweep_idx_r == SW_LAST) begin
            state_r     <= RUN;
            sweep_idx_r <= {SW_W{1'b0}};
          end else begin
            sweep_idx_r <= sweep_idx_r + SW_ONE;
          end
        end
        RUN: begin
          state_r <= RUN;
        end
        default: begin
          state_r     <= INIT;
          sweep_idx_r <= {SW_W{1'b0}};
        end
      endcase
    end
  end

  // Table writes: one sweep entry per cycle in INIT, trained updates in RUN.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == INIT)) begin
      if (sweep_in_pht_s) pht_r[sweep_idx_r[PHT_IDX_W-1:0]] <= CTR_INIT;
      if (sweep_in_bht_s) bht_r[sweep_idx_r[BHT_IDX_W-1:0]] <= {HIST_W{1'b0}};
    end else if (!rst && upd_s) begin
      pht_r[pht_idx_m_s] <= ctr_new_m_s;
      bht_r[pc_idx_M]    <= new_hist_s;
    end
  end

  // Saturating performance counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      br_cnt  <= {CNT_W{1'b0}};
      mis_cnt <= {CNT_W{1'b0}};
    end else if (upd_s) begin
      if (br_cnt != CNT_MAX) br_cnt <= br_cnt + CNT_ONE;
      if (mispredict_M && (mis_cnt != CNT_MAX)) mis_cnt <= mis_cnt + CNT_ONE;
    end
  end

endmodule
